// File: rtl/la_rrarb_pick.sv
// Rotating-priority find-first: the lowest set bit of (req & ~excl) at or above
// ptr+1, wrapping at N, wins. Purely combinational.
module la_rrarb_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         excl,
    output logic [N-1:0]         win,
    output logic [$clog2(N)-1:0] win_id,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [N-1:0] cand;
    logic [N-1:0] rot;
    int           start;

    always_comb begin
        cand   = req & ~excl;
        start  = (int'(ptr) + 1) % N;
        // Doubling the vector makes the wrap-around a plain right shift.
        rot    = N'({cand, cand} >> start);
        win    = '0;
        win_id = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !any) begin
                any    = 1'b1;
                win_id = IW'((start + k) % N);
            end
        end
        if (any) begin
            win[win_id] = 1'b1;
        end
    end

endmodule

// File: rtl/la_rrarb.sv
// Round-robin arbiter: registered one-hot grant held until the owner drops its
// request, with an optional hold limit that forces rotation.
module la_rrarb #(
    parameter int    N       = 4,
    parameter int    HOLDMAX = 0,
    parameter string PROP    = "DEFAULT"
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int IW = $clog2(N);
    localparam int HW = (HOLDMAX > 0) ? $clog2(HOLDMAX + 1) : 1;
    localparam logic [HW-1:0] HCNT_SAT = (HOLDMAX > 0) ? HW'(HOLDMAX - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Technology-mapping hook; an empty PROP string selects no special mapping.
    if (PROP == "") begin : g_prop_none
    end

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;

    logic [N-1:0]  pick_win;
    logic [IW-1:0] pick_id;
    logic          pick_any;
    logic          owner_req;
    logic          hold_hit;
    logic          take;

    // Excluding the current owner is a no-op on release (its req is low), and
    // on a hold-limit trigger it yields "next winner other than g".
    la_rrarb_pick #(
        .N (N)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (gnt_q),
        .win    (pick_win),
        .win_id (pick_id),
        .any    (pick_any)
    );

    assign owner_req = |(req & gnt_q);
    assign hold_hit  = (HOLDMAX > 0) && (hcnt_q == HCNT_SAT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hcnt_d      = hcnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        take        = 1'b0;
        case (state_q)
            IDLE: begin
                take = en && pick_any;
            end
            GRANT: begin
                if (!owner_req) begin
                    take = en && pick_any;
                    if (!take) begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                        gnt_id_d    = '0;
                        hcnt_d      = '0;
                    end
                end else if (hold_hit && en && pick_any) begin
                    take = 1'b1;
                end else if ((HOLDMAX > 0) && (hcnt_q != HCNT_SAT)) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            state_d     = GRANT;
            gnt_d       = pick_win;
            gnt_valid_d = 1'b1;
            gnt_id_d    = pick_id;
            ptr_d       = pick_id;
            hcnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N - 1);
            hcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule
